// File: rtl/pipeline_ctrl_if.sv
// Stall/exception handshake between pipeline stages and the central controller.
// master = pipeline stages raising requests; slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             if_stall_req;
   logic             id_stall_req;
   logic             ex_stall_req;
   logic             mem_stall_req;
   logic             exc_valid;
   logic [31:0]      exc_handler;
   logic [4:0]       stall;
   logic [4:0]       bubble;
   logic [4:0]       flush;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             exc_ack;
   logic [CNT_W-1:0] stall_cycles;
   logic             stall_timeout;

   modport master (
      output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_valid, exc_handler,
      input  stall, bubble, flush, redirect_valid, redirect_pc, exc_ack, stall_cycles,
             stall_timeout
   );

   modport slave (
      input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_valid, exc_handler,
      output stall, bubble, flush, redirect_valid, redirect_pc, exc_ack, stall_cycles,
             stall_timeout
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall arbitration, precise-exception sequencing
// (drain, flush, redirect), saturating stall counter and stall watchdog.
module pipeline_ctrl #(
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned CNT_W   = 32
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);

   localparam int unsigned    WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

   state_e           state_q;
   logic             flush_q;
   logic [31:0]      redirect_pc_q;
   logic [CNT_W-1:0] stall_cycles_q;
   logic [WD_W-1:0]  wd_cnt_q;
   logic             timeout_q;
   logic [4:0]       stall_c;

   always_comb begin
      stall_c = '0;
      case (state_q)
         StIdle: begin
            if (bus.exc_valid)          stall_c = 5'b11111;
            else if (bus.mem_stall_req) stall_c = 5'b01111;
            else if (bus.ex_stall_req)  stall_c = 5'b00111;
            else if (bus.id_stall_req)  stall_c = 5'b00011;
            else if (bus.if_stall_req)  stall_c = 5'b00001;
         end
         StDrain: stall_c = 5'b11111;
         default: stall_c = '0;
      endcase
   end

   assign bus.stall          = stall_c;
   // A register gets a NOP when its upstream neighbour holds but it advances.
   assign bus.bubble         = {stall_c[3:0] & ~stall_c[4:1], 1'b0};
   assign bus.flush          = {5{flush_q}};
   assign bus.redirect_valid = flush_q;
   assign bus.exc_ack        = flush_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.stall_cycles   = stall_cycles_q;
   assign bus.stall_timeout  = timeout_q;

   // flush_q is set exactly on entry to StFlush, so it marks the single flush cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.exc_valid) begin
                  redirect_pc_q <= bus.exc_handler;
                  if (bus.mem_stall_req) begin
                     state_q <= StDrain;
                  end else begin
                     state_q <= StFlush;
                     flush_q <= 1'b1;
                  end
               end
            end
            StDrain: begin
               if (!bus.mem_stall_req) begin
                  state_q <= StFlush;
                  flush_q <= 1'b1;
               end
            end
            StFlush: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         wd_cnt_q       <= '0;
         timeout_q      <= 1'b0;
      end else begin
         if ((|stall_c) && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
         end
         if (stall_c[0]) begin
            if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + WD_W'(1);
            if (wd_cnt_q == WD_MAX) timeout_q <= 1'b1;
         end else begin
            wd_cnt_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=8, CNT_W=5).
module tb_pipeline_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_ctrl_if #(.CNT_W(5)) bus ();

   pipeline_ctrl #(
      .TIMEOUT (8),
      .CNT_W   (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.if_stall_req  = 1'b0;
      bus.id_stall_req  = 1'b0;
      bus.ex_stall_req  = 1'b0;
      bus.mem_stall_req = 1'b0;
      bus.exc_valid     = 1'b0;
      bus.exc_handler   = 32'h0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      settle();
      check("rst_stall",   32'(bus.stall),          32'h0);
      check("rst_bubble",  32'(bus.bubble),         32'h0);
      check("rst_flush",   32'(bus.flush),          32'h0);
      check("rst_rv",      32'(bus.redirect_valid), 32'h0);
      check("rst_ack",     32'(bus.exc_ack),        32'h0);
      check("rst_pc",      bus.redirect_pc,         32'h0);
      check("rst_cycles",  32'(bus.stall_cycles),   32'h0);
      check("rst_timeout", 32'(bus.stall_timeout),  32'h0);

      // ID load-use stall for one cycle
      bus.id_stall_req = 1'b1;
      settle();
      check("id_stall",  32'(bus.stall),  32'h03);
      check("id_bubble", 32'(bus.bubble), 32'h04);
      tick();
      clear_inputs();
      settle();
      check("id_release", 32'(bus.stall),        32'h0);
      check("id_cycles",  32'(bus.stall_cycles), 32'd1);

      // All requests together: MEM wins
      bus.mem_stall_req = 1'b1;
      bus.ex_stall_req  = 1'b1;
      bus.id_stall_req  = 1'b1;
      bus.if_stall_req  = 1'b1;
      settle();
      check("prio_stall",  32'(bus.stall),  32'h0f);
      check("prio_bubble", 32'(bus.bubble), 32'h10);
      tick();
      clear_inputs();
      bus.ex_stall_req = 1'b1;
      settle();
      check("ex_stall",  32'(bus.stall),        32'h07);
      check("ex_bubble", 32'(bus.bubble),       32'h08);
      check("prio_cyc",  32'(bus.stall_cycles), 32'd2);
      tick();
      clear_inputs();
      settle();
      check("ex_cyc", 32'(bus.stall_cycles), 32'd3);

      // Exception with MEM idle: one hold cycle, then flush
      bus.exc_valid   = 1'b1;
      bus.exc_handler = 32'hBFC0_0380;
      settle();
      check("exc0_stall",  32'(bus.stall),  32'h1f);
      check("exc0_bubble", 32'(bus.bubble), 32'h0);
      check("exc0_flush",  32'(bus.flush),  32'h0);
      check("exc0_rv",     32'(bus.redirect_valid), 32'h0);
      tick();
      settle();
      check("exc1_flush", 32'(bus.flush),          32'h1f);
      check("exc1_rv",    32'(bus.redirect_valid), 32'h1);
      check("exc1_pc",    bus.redirect_pc,         32'hBFC0_0380);
      check("exc1_ack",   32'(bus.exc_ack),        32'h1);
      check("exc1_stall", 32'(bus.stall),          32'h0);
      tick();
      clear_inputs();
      settle();
      check("exc2_flush", 32'(bus.flush),          32'h0);
      check("exc2_rv",    32'(bus.redirect_valid), 32'h0);
      check("exc2_ack",   32'(bus.exc_ack),        32'h0);
      check("exc2_stall", 32'(bus.stall),          32'h0);
      check("exc2_cyc",   32'(bus.stall_cycles),   32'd4);

      // Exception while MEM busy: drain, handler change ignored
      bus.exc_valid     = 1'b1;
      bus.exc_handler   = 32'hBFC0_0200;
      bus.mem_stall_req = 1'b1;
      settle();
      check("drn_idle_stall", 32'(bus.stall), 32'h1f);
      tick();
      bus.exc_handler = 32'h8000_0180;
      settle();
      check("drn1_stall", 32'(bus.stall),          32'h1f);
      check("drn1_bub",   32'(bus.bubble),         32'h0);
      check("drn1_rv",    32'(bus.redirect_valid), 32'h0);
      tick();
      settle();
      check("drn2_stall", 32'(bus.stall), 32'h1f);
      check("drn2_flush", 32'(bus.flush), 32'h0);
      tick();
      bus.mem_stall_req = 1'b0;
      settle();
      check("drn3_stall", 32'(bus.stall), 32'h1f);
      tick();
      settle();
      check("drn_flush", 32'(bus.flush),          32'h1f);
      check("drn_rv",    32'(bus.redirect_valid), 32'h1);
      check("drn_ack",   32'(bus.exc_ack),        32'h1);
      check("drn_pc",    bus.redirect_pc,         32'hBFC0_0200);
      tick();
      clear_inputs();
      settle();
      check("drn_done_flush", 32'(bus.flush),        32'h0);
      check("drn_cyc",        32'(bus.stall_cycles), 32'd8);

      // Watchdog: IF stall held 8 cycles
      bus.if_stall_req = 1'b1;
      settle();
      check("if_stall",  32'(bus.stall),  32'h01);
      check("if_bubble", 32'(bus.bubble), 32'h02);
      for (int i = 0; i < 7; i++) tick();
      check("wd_pre", 32'(bus.stall_timeout), 32'h0);
      tick();
      clear_inputs();
      settle();
      check("wd_set", 32'(bus.stall_timeout), 32'h1);
      tick();
      tick();
      check("wd_sticky", 32'(bus.stall_timeout), 32'h1);
      check("wd_cyc",    32'(bus.stall_cycles),  32'd16);

      // Reset in the middle of a drain
      bus.exc_valid     = 1'b1;
      bus.exc_handler   = 32'h1234_5678;
      bus.mem_stall_req = 1'b1;
      tick();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
      settle();
      check("rdrn_stall",   32'(bus.stall),          32'h0);
      check("rdrn_flush",   32'(bus.flush),          32'h0);
      check("rdrn_rv",      32'(bus.redirect_valid), 32'h0);
      check("rdrn_pc",      bus.redirect_pc,         32'h0);
      check("rdrn_cyc",     32'(bus.stall_cycles),   32'h0);
      check("rdrn_timeout", 32'(bus.stall_timeout),  32'h0);
      tick();
      check("rdrn_rv2",    32'(bus.redirect_valid), 32'h0);
      check("rdrn_flush2", 32'(bus.flush),          32'h0);

      // Counter saturation at 5'h1f
      bus.if_stall_req = 1'b1;
      for (int i = 0; i < 31; i++) tick();
      check("sat_full", 32'(bus.stall_cycles), 32'd31);
      tick();
      tick();
      check("sat_hold", 32'(bus.stall_cycles), 32'd31);
      clear_inputs();
      tick();
      check("sat_idle", 32'(bus.stall_cycles), 32'd31);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
